// File: rtl/management_register_interface_pkg.sv
// mgmt_regs_pkg: register map constants and defaults shared by the management register interface.
// Contents:
//   NUM_PORTS_DEF / VLAN_BITS_DEF : default parameter values
//   REG_*                         : byte addresses of the register map
//   STATUS_*_BIT                  : bit positions inside the status register
package mgmt_regs_pkg;
    localparam int NUM_PORTS_DEF = 15;
    localparam int VLAN_BITS_DEF = 12;
    localparam logic [15:0] REG_IDCODE_0  = 16'h0000;
    localparam logic [15:0] REG_STATUS    = 16'h0004;
    localparam logic [15:0] REG_SERIAL_0  = 16'h0008;
    localparam logic [15:0] REG_SCRATCH   = 16'h0010;
    localparam logic [15:0] REG_VLAN_BASE = 16'h0100;
    localparam int STATUS_IDCODE_BIT = 0;
    localparam int STATUS_SERIAL_BIT = 1;
endpackage

// File: rtl/management_register_interface_port_vlan_table.sv
// port_vlan_table: per-port default RX VLAN storage with its write decode and read mux.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   wr_en/addr/data : byte write from the management bridge
//   rd_addr         : byte read address (combinational lookup)
//   rd_hit          : rd_addr falls inside the VLAN window
//   rd_byte         : addressed byte, 0 when not hit
//   port_rx_vlan    : flattened VLAN table, port p at [p*VLAN_BITS +: VLAN_BITS]
module port_vlan_table
    import mgmt_regs_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int VLAN_BITS = VLAN_BITS_DEF,
    parameter logic [VLAN_BITS-1:0] DEFAULT_VLAN = {{(VLAN_BITS-1){1'b0}}, 1'b1}
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [15:0]                    wr_addr,
    input  logic [7:0]                     wr_data,
    input  logic [15:0]                    rd_addr,
    output logic                           rd_hit,
    output logic [7:0]                     rd_byte,
    output logic [NUM_PORTS*VLAN_BITS-1:0] port_rx_vlan
);
    logic [VLAN_BITS-1:0] vlan [NUM_PORTS];
    logic [15:0] wr_off;
    logic [15:0] rd_off;
    logic        wr_in;

    // Offsets wrap below the base, so the >= test keeps low addresses out.
    assign wr_off = wr_addr - REG_VLAN_BASE;
    assign rd_off = rd_addr - REG_VLAN_BASE;
    assign wr_in  = wr_addr >= REG_VLAN_BASE && wr_off < 16'(2*NUM_PORTS);
    assign rd_hit = rd_addr >= REG_VLAN_BASE && rd_off < 16'(2*NUM_PORTS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) vlan[p] <= DEFAULT_VLAN;
        end else if (wr_en && wr_in) begin
            for (int p = 0; p < NUM_PORTS; p++)
                if (wr_off[15:1] == 15'(p)) begin
                    if (wr_off[0]) vlan[p][VLAN_BITS-1:8] <= wr_data[VLAN_BITS-9:0];
                    else vlan[p][7:0] <= wr_data;
                end
        end
    end

    // Upper nibble of the high byte is not stored and reads back as zero.
    always_comb begin
        rd_byte = 8'h00;
        for (int p = 0; p < NUM_PORTS; p++)
            if (rd_hit && rd_off[15:1] == 15'(p))
                rd_byte = rd_off[0] ? 8'(vlan[p][VLAN_BITS-1:8]) : vlan[p][7:0];
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
        assign port_rx_vlan[g*VLAN_BITS +: VLAN_BITS] = vlan[g];
    end
endmodule

// File: rtl/management_register_interface.sv
// management_register_interface: byte register file for device identity, scratch and per-port VLAN config.
// Ports:
//   clk, rst_n                    : management clock, asynchronous active-low reset
//   rd_en, rd_addr                : one-cycle read request
//   rd_valid, rd_data             : registered read response one cycle later
//   wr_en, wr_addr, wr_data       : one-cycle byte write
//   idcode_valid, idcode          : IDCODE producer, latched once
//   die_serial_valid, die_serial  : serial producer, latched once
//   port_rx_vlan                  : per-port default RX VLAN table
module management_register_interface
    import mgmt_regs_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int VLAN_BITS = VLAN_BITS_DEF,
    parameter logic [VLAN_BITS-1:0] DEFAULT_VLAN = {{(VLAN_BITS-1){1'b0}}, 1'b1}
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rd_en,
    input  logic [15:0]                    rd_addr,
    output logic                           rd_valid,
    output logic [7:0]                     rd_data,
    input  logic                           wr_en,
    input  logic [15:0]                    wr_addr,
    input  logic [7:0]                     wr_data,
    input  logic                           die_serial_valid,
    input  logic [63:0]                    die_serial,
    input  logic                           idcode_valid,
    input  logic [31:0]                    idcode,
    output logic [NUM_PORTS*VLAN_BITS-1:0] port_rx_vlan
);
    logic [31:0] idcode_q;
    logic [63:0] serial_q;
    logic        id_ok;
    logic        ser_ok;
    logic [7:0]  scratch;
    logic [7:0]  rd_next;
    logic        vlan_hit;
    logic [7:0]  vlan_byte;

    port_vlan_table #(
        .NUM_PORTS    (NUM_PORTS),
        .VLAN_BITS    (VLAN_BITS),
        .DEFAULT_VLAN (DEFAULT_VLAN)
    ) u_vlan (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr      (rd_addr),
        .rd_hit       (vlan_hit),
        .rd_byte      (vlan_byte),
        .port_rx_vlan (port_rx_vlan)
    );

    always_comb begin
        rd_next = 8'h00;
        if (rd_addr[15:2] == REG_IDCODE_0[15:2]) rd_next = idcode_q[8*rd_addr[1:0] +: 8];
        else if (rd_addr == REG_STATUS) begin
            rd_next[STATUS_IDCODE_BIT] = id_ok;
            rd_next[STATUS_SERIAL_BIT] = ser_ok;
        end
        else if (rd_addr[15:3] == REG_SERIAL_0[15:3]) rd_next = serial_q[8*rd_addr[2:0] +: 8];
        else if (rd_addr == REG_SCRATCH) rd_next = scratch;
        else if (vlan_hit) rd_next = vlan_byte;
    end

    // Read data is sampled from pre-edge state, so a same-cycle write is not visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
            idcode_q <= '0;
            serial_q <= '0;
            id_ok    <= 1'b0;
            ser_ok   <= 1'b0;
            scratch  <= 8'h00;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_next;
            if (idcode_valid && !id_ok) begin
                idcode_q <= idcode;
                id_ok    <= 1'b1;
            end
            if (die_serial_valid && !ser_ok) begin
                serial_q <= die_serial;
                ser_ok   <= 1'b1;
            end
            if (wr_en && wr_addr == REG_SCRATCH) scratch <= wr_data;
        end
    end
endmodule

// File: tb/tb_management_register_interface.sv
// tb_management_register_interface: directed plus randomized check of the register interface against a map-level model.
module tb_management_register_interface;
    localparam int NP = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_en = 1'b0;
    logic [15:0]   rd_addr = '0;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic          wr_en = 1'b0;
    logic [15:0]   wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          die_serial_valid = 1'b0;
    logic [63:0]   die_serial = '0;
    logic          idcode_valid = 1'b0;
    logic [31:0]   idcode = '0;
    logic [NP*12-1:0] port_rx_vlan;

    management_register_interface dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .die_serial_valid (die_serial_valid),
        .die_serial       (die_serial),
        .idcode_valid     (idcode_valid),
        .idcode           (idcode),
        .port_rx_vlan     (port_rx_vlan)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] m_id;
    logic [63:0] m_ser;
    bit          m_id_ok, m_ser_ok;
    int          m_scr;
    int          m_vlan [NP];
    logic [7:0]  m_rd;
    bit          m_rv;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_id = 0; m_ser = 0; m_id_ok = 0; m_ser_ok = 0; m_scr = 0;
        m_rd = 0; m_rv = 0;
        for (int p = 0; p < NP; p++) m_vlan[p] = 1;
    endtask

    function automatic logic [7:0] mref(input int a);
        if (a < 4) return 8'((m_id >> (8*a)) & 32'hFF);
        if (a == 4) return {6'd0, m_ser_ok, m_id_ok};
        if (a >= 8 && a < 16) return 8'((m_ser >> (8*(a-8))) & 64'hFF);
        if (a == 16) return 8'(m_scr);
        if (a >= 256 && a < 256 + 2*NP)
            return (a % 2) ? 8'(m_vlan[(a-256)/2] >> 8) : 8'(m_vlan[(a-256)/2] & 'hFF);
        return 8'h00;
    endfunction

    task automatic model_write(input int a, input int d);
        if (a == 16) m_scr = d;
        else if (a >= 256 && a < 256 + 2*NP) begin
            if (a % 2) m_vlan[(a-256)/2] = (m_vlan[(a-256)/2] & 'hFF) | ((d & 'hF) << 8);
            else m_vlan[(a-256)/2] = (m_vlan[(a-256)/2] & 'hF00) | d;
        end
    endtask

    task automatic check_vlan();
        for (int p = 0; p < NP; p++)
            check($sformatf("vlan%0d", p), 64'(port_rx_vlan[p*12 +: 12]), 64'(m_vlan[p]));
    endtask

    // One clock: drive, let the model see the same edge, then compare #1 after it.
    task automatic step(input bit rd, input logic [15:0] ra, input bit wr, input logic [15:0] wa, input logic [7:0] wd);
        rd_en = rd; rd_addr = ra; wr_en = wr; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        m_rv = rd;
        if (rd) m_rd = mref(int'(ra));
        if (wr) model_write(int'(wa), int'(wd));
        if (idcode_valid && !m_id_ok) begin m_id = idcode; m_id_ok = 1; end
        if (die_serial_valid && !m_ser_ok) begin m_ser = die_serial; m_ser_ok = 1; end
        #1;
        rd_en = 0; wr_en = 0;
        check("rd_valid", 64'(rd_valid), 64'(m_rv));
        check($sformatf("rd_data@%04h", ra), 64'(rd_data), 64'(m_rd));
        check_vlan();
    endtask

    task automatic rd(input logic [15:0] a);
        step(1, a, 0, 0, 0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        step(0, 0, 1, a, d);
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 2))
            0: return 16'($urandom_range(0, 17));
            1: return 16'($urandom_range(16'h00FE, 16'h0121));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_valid", 64'(rd_valid), 0);
        check("reset_rd_data", 64'(rd_data), 0);
        check_vlan();
        rst_n = 1;

        rd(16'h0004);
        for (int a = 16'h0100; a < 16'h0100 + 2*NP; a++) rd(16'(a));

        idcode = 32'h3636_1093; idcode_valid = 1;
        step(0, 0, 0, 0, 0);
        idcode_valid = 0;
        for (int a = 0; a < 5; a++) rd(16'(a));
        idcode = 32'hDEAD_BEEF; idcode_valid = 1;
        step(0, 0, 0, 0, 0);
        idcode_valid = 0;
        for (int a = 0; a < 4; a++) rd(16'(a));
        check("idcode_byte3_kept", 64'(rd_data), 64'h36);

        die_serial = 64'h0123_4567_89AB_CDEF; die_serial_valid = 1;
        step(0, 0, 0, 0, 0);
        die_serial_valid = 0;
        for (int a = 8; a < 16; a++) rd(16'(a));
        rd(16'h0004);
        check("status_both", 64'(rd_data), 64'h03);

        wr(16'h0106, 8'hA5);
        wr(16'h0107, 8'hFF);
        check("port3_vlan", 64'(port_rx_vlan[47:36]), 64'hFA5);
        rd(16'h0107);
        check("vlan_hi_mask", 64'(rd_data), 64'h0F);
        wr(16'h0120, 8'h77);
        rd(16'h0120);
        check("unmapped_rd", 64'(rd_data), 64'h00);

        step(1, 16'h0010, 1, 16'h0010, 8'h5A);
        check("rw_same_old", 64'(rd_data), 64'h00);
        rd(16'h0010);
        check("scratch_new", 64'(rd_data), 64'h5A);
        rd(16'h0000); rd(16'h0001); rd(16'h0002);

        rd_en = 1; rd_addr = 16'h0000;
        @(posedge clk);
        #1;
        rst_n = 0; rd_en = 0;
        #1;
        check("rst_drops_valid", 64'(rd_valid), 0);
        @(posedge clk);
        #1;
        check("rst_rd_valid", 64'(rd_valid), 0);
        check("rst_rd_data", 64'(rd_data), 0);
        model_reset();
        check_vlan();
        rst_n = 1;
        rd(16'h0010);
        rd(16'h0106);
        rd(16'h0107);
        rd(16'h0004);

        for (int i = 0; i < 400; i++) begin
            idcode = $urandom;
            die_serial = {$urandom, $urandom};
            idcode_valid = ($urandom_range(0, 15) == 0);
            die_serial_valid = ($urandom_range(0, 15) == 0);
            step($urandom_range(0, 1) == 1, rand_addr(), $urandom_range(0, 1) == 1, rand_addr(), 8'($urandom));
        end
        idcode_valid = 0; die_serial_valid = 0;
        for (int a = 0; a < 17; a++) rd(16'(a));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
